// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared sizing constants and the read-credit helper for the
// FIFO read-side stream adapter.
package fifo_stream_pkg;

  localparam int DEFAULT_DATA_W = 3;
  localparam int BUF_DEPTH      = 2;
  localparam int OCC_W          = 2;
  localparam int CNT_W          = 16;

  // A new read may be issued only if every word already owed to the output
  // buffer (held, or still coming back from the FIFO) still leaves a free slot
  // after this cycle's pop.
  function automatic logic has_credit(input logic [OCC_W-1:0] occ,
                                      input logic             inflight,
                                      input logic             pop);
    logic [2:0] owed;
    owed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return owed < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/stream_out_buf.sv
// stream_out_buf: two-entry ordered output buffer. Slot 0 is always the head,
// so the head word is a plain register and stays put while nothing is popped.
module stream_out_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [OCC_W-1:0]  occ_o,
  output logic [DATA_W-1:0] head_data_o
);

  logic [OCC_W-1:0]  occ;
  logic [DATA_W-1:0] slot0;
  logic [DATA_W-1:0] slot1;

  // Shift organisation: a pop moves slot 1 into slot 0, a push lands at the
  // current tail, and a simultaneous push/pop keeps the order intact.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      occ   <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (occ == 2'd0) begin
            slot0 <= push_data_i;
          end else begin
            slot1 <= push_data_i;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            slot0 <= push_data_i;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign occ_o       = occ;
  assign head_data_o = slot0;

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous_fifo (one-cycle read latency) and
// presents the words as a valid/ready stream at full throughput.
// Optional feature: define FRD_COUNT_EN to add the rd_count_o delivered-word
// counter port.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_data_i,
  input  logic              m_ready_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o
`ifdef FRD_COUNT_EN
  ,
  output logic [CNT_W-1:0]  rd_count_o
`endif
);

  logic             inflight;
  logic             pop;
  logic [OCC_W-1:0] occ;

  assign m_valid_o = (occ != '0);
  assign pop       = m_valid_o && m_ready_i;

  // The path from m_ready_i into fifo_rd_en_o is deliberate: counting this
  // cycle's pop as freed credit is what lets the stream run at one word/cycle.
  assign fifo_rd_en_o = !reset_i && !fifo_empty_i && has_credit(occ, inflight, pop);

  // Remember that a read was issued so its data is captured next cycle.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en_o;
    end
  end

  stream_out_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk         (clk),
    .reset_i     (reset_i),
    .push_i      (inflight),
    .push_data_i (fifo_data_i),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_data_o (m_data_o)
  );

`ifdef FRD_COUNT_EN
  logic [CNT_W-1:0] rd_count;

  // Count delivered words; wraps naturally at the counter width.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      rd_count <= '0;
    end else if (pop) begin
      rd_count <= rd_count + 1'b1;
    end
  end

  assign rd_count_o = rd_count;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed bench with a behavioural FIFO and a
// scoreboard of words written into it, compared as words leave the stream.
module tb_fifo_stream_reader;

  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data = '0;
  logic          m_ready = 1'b0;
  logic          m_valid;
  logic [DW-1:0] m_data;
`ifdef FRD_COUNT_EN
  logic [15:0]   rd_count;
`endif

  int total = 0;
  int bad = 0;

  logic [DW-1:0] pend_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sb[$];

  int reads = 0;
  int xfers = 0;
  int cnt_model = 0;

  fifo_stream_reader #(.DATA_W(DW)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_en_o (fifo_rd_en),
    .fifo_data_i  (fifo_data),
    .m_ready_i    (m_ready),
    .m_valid_o    (m_valid),
    .m_data_o     (m_data)
`ifdef FRD_COUNT_EN
    ,
    .rd_count_o   (rd_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural synchronous FIFO: registered read data, writes land at the edge.
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() != 0) begin
      fifo_data <= fifo_q.pop_front();
    end
    while (pend_q.size() != 0) begin
      fifo_q.push_back(pend_q.pop_front());
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load words first..first+count-1 (mod 8) into the FIFO and the scoreboard.
  task automatic applyStimulus(input logic ready, input int first, input int count);
    m_ready = ready;
    for (int i = 0; i < count; i++) begin
      pend_q.push_back(DW'((first + i) % 8));
      sb.push_back(DW'((first + i) % 8));
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput(tag, 32'(sb.size()), 32'd0);
  endtask

  // Monitor just before each rising edge: stream order, no empty reads, credit.
  always @(negedge clk) begin
    #4;
    if (reset_i) begin
      reads = 0;
      xfers = 0;
      cnt_model = 0;
    end else begin
      checkOutput("rd_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $error("[TB] FAIL sb_underflow observed=%0h expected=none", m_data);
        end else begin
          checkOutput("stream_data", 32'(m_data), 32'(sb.pop_front()));
        end
        xfers++;
        cnt_model = (cnt_model + 1) % 65536;
      end
      if (fifo_rd_en) reads++;
      checkOutput("credit", 32'((reads - xfers) <= 2), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit rd_log[16];
    bit v_log[16];
    logic [DW-1:0] d_log[16];
    int rd_first, rd_run, v_first, v_run, n_rd, x0, guard;

    // Reset held with a non-empty FIFO.
    @(negedge clk);
    applyStimulus(1'b1, 5, 3);
    sb.delete();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checkOutput("reset_valid", 32'(m_valid), 32'd0);
      checkOutput("reset_rd_en", 32'(fifo_rd_en), 32'd0);
      checkOutput("reset_data", 32'(m_data), 32'd0);
`ifdef FRD_COUNT_EN
      checkOutput("reset_count", 32'(rd_count), 32'd0);
`endif
    end
    fifo_q.delete();
    pend_q.delete();
    m_ready = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;

    // Streaming with the consumer always ready.
    @(negedge clk);
    applyStimulus(1'b1, 0, 8);
    for (int c = 0; c < 16; c++) begin
      #1;
      rd_log[c] = fifo_rd_en;
      v_log[c] = m_valid;
      d_log[c] = m_data;
      @(negedge clk);
    end
    rd_first = 0;
    while (rd_first < 15 && !rd_log[rd_first]) rd_first++;
    rd_run = 0;
    for (int c = rd_first; c < 16 && rd_log[c]; c++) rd_run++;
    v_first = 0;
    while (v_first < 15 && !v_log[v_first]) v_first++;
    v_run = 0;
    for (int c = v_first; c < 16 && v_log[c]; c++) begin
      checkOutput("stream_order", 32'(d_log[c]), 32'(c - v_first));
      v_run++;
    end
    checkOutput("stream_rd_run", 32'(rd_run), 32'd8);
    checkOutput("stream_latency", 32'(v_first - rd_first), 32'd2);
    checkOutput("stream_valid_run", 32'(v_run), 32'd8);
`ifdef FRD_COUNT_EN
    checkOutput("stream_count", 32'(rd_count), 32'd8);
`endif

    // Backpressure: only two reads, head word held.
    applyStimulus(1'b0, 0, 8);
    n_rd = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (fifo_rd_en) n_rd++;
      if (c >= 5) checkOutput("bp_hold", {30'd0, m_valid, 1'b0} | 32'(m_data), 32'd2);
      @(negedge clk);
    end
    checkOutput("bp_reads", 32'(n_rd), 32'd2);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput("bp_release_valid", 32'(m_valid), 32'd1);
      checkOutput("bp_release_data", 32'(m_data), 32'(i));
      @(negedge clk);
    end
    #1;
    checkOutput("bp_done_valid", 32'(m_valid), 32'd0);

    // Random consumer readiness with 16 interleaved writes.
    void'($urandom(32'd2024));
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      if (c % 2 == 0) applyStimulus(m_ready, (c / 2) % 8, 1);
    end
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      guard++;
    end
    checkOutput("rand_drain", 32'(sb.size()), 32'd0);

    // Empty FIFO: nothing read, nothing presented.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      m_ready = 1'(c % 2);
      #1;
      checkOutput("empty_idle", {30'd0, fifo_rd_en, m_valid}, 32'd0);
    end

    // Reset after three transfers with two words buffered.
    @(negedge clk);
    x0 = xfers;
    applyStimulus(1'b1, 0, 8);
    guard = 0;
    while ((xfers - x0) < 3 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("mid_three_xfers", 32'(xfers - x0), 32'd3);
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("mid_full_valid", 32'(m_valid), 32'd1);
    checkOutput("mid_full_data", 32'(m_data), 32'd3);
`ifdef FRD_COUNT_EN
    checkOutput("mid_count", 32'(rd_count), 32'(cnt_model));
`endif
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("mid_reset_valid", 32'(m_valid), 32'd0);
    checkOutput("mid_reset_rd_en", 32'(fifo_rd_en), 32'd0);
`ifdef FRD_COUNT_EN
    checkOutput("mid_reset_count", 32'(rd_count), 32'd0);
`endif
    fifo_q.delete();
    pend_q.delete();
    sb.delete();
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 0, 8);
    guard = 0;
    #1;
    while (!m_valid && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checkOutput("restart_valid", 32'(m_valid), 32'd1);
    checkOutput("restart_data", 32'(m_data), 32'd0);
    drain("restart_drain");
    repeat (2) @(negedge clk);
    #1;
`ifdef FRD_COUNT_EN
    checkOutput("restart_count", 32'(rd_count), 32'd8);
`endif
    checkOutput("final_valid", 32'(m_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
